// File: rtl/bus_master_arbiter.sv
// Two-master request/grant arbiter in front of the serial system bus.
// Round-robin on ties, programmable turnaround gap, per-grant hold timeout.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rstn         asynchronous active-low reset
//   m1_breq      M1 bus request, held high for the whole transaction
//   m2_breq      M2 bus request, held high for the whole transaction
//   m1_bgrant    M1 owns the bus (registered)
//   m2_bgrant    M2 owns the bus (registered)
//   m1_timeout   1-cycle pulse: M1 grant revoked by timeout
//   m2_timeout   1-cycle pulse: M2 grant revoked by timeout
//   bus_sel      mux select, 0 = M1, 1 = M2; holds last owner when idle
//   bus_busy     m1_bgrant | m2_bgrant
module bus_master_arbiter #(
    parameter int TIMEOUT    = 1024,
    parameter int TURNAROUND = 1,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic m1_breq,
    input  logic m2_breq,
    output logic m1_bgrant,
    output logic m2_bgrant,
    output logic m1_timeout,
    output logic m2_timeout,
    output logic bus_sel,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE,
        GNT1,
        GNT2,
        TURN
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TA_VAL = CNT_W'(TURNAROUND);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic             TO_EN  = (TIMEOUT != 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] turn_q;
    logic [CNT_W-1:0] turn_d;
    // last owner: 0 = M1, 1 = M2
    logic             last_q;
    logic             last_d;
    logic             sel_q;
    logic             sel_d;
    logic             arm1_q;
    logic             arm1_d;
    logic             arm2_q;
    logic             arm2_d;
    logic             to1_q;
    logic             to1_d;
    logic             to2_q;
    logic             to2_d;
    logic             g1_q;
    logic             g2_q;

    logic             elig1;
    logic             elig2;
    logic             pick1;
    logic             pick2;
    logic             decide;

    // A master that timed out stays disarmed until it drops its request.
    assign elig1 = m1_breq & arm1_q;
    assign elig2 = m2_breq & arm2_q;

    // On a tie the master that did not own the bus last wins.
    assign pick1 = elig1 & (~elig2 | last_q);
    assign pick2 = elig2 & (~elig1 | ~last_q);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        last_d  = last_q;
        sel_d   = sel_q;
        to1_d   = 1'b0;
        to2_d   = 1'b0;
        arm1_d  = arm1_q | ~m1_breq;
        arm2_d  = arm2_q | ~m2_breq;
        decide  = 1'b0;

        unique case (state_q)
            IDLE: begin
                decide = 1'b1;
            end
            GNT1: begin
                if (!m1_breq) begin
                    state_d = TURN;
                    turn_d  = ONE;
                end else if (TO_EN && hold_q == TO_VAL) begin
                    state_d = TURN;
                    turn_d  = ONE;
                    to1_d   = 1'b1;
                    arm1_d  = 1'b0;
                end else if (TO_EN) begin
                    hold_d = hold_q + ONE;
                end
            end
            GNT2: begin
                if (!m2_breq) begin
                    state_d = TURN;
                    turn_d  = ONE;
                end else if (TO_EN && hold_q == TO_VAL) begin
                    state_d = TURN;
                    turn_d  = ONE;
                    to2_d   = 1'b1;
                    arm2_d  = 1'b0;
                end else if (TO_EN) begin
                    hold_d = hold_q + ONE;
                end
            end
            TURN: begin
                // Last gap cycle arbitrates exactly like IDLE.
                if (turn_q >= TA_VAL) begin
                    decide = 1'b1;
                end else begin
                    turn_d = turn_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            state_d = IDLE;
            turn_d  = '0;
            unique case (1'b1)
                pick1: begin
                    state_d = GNT1;
                    hold_d  = ONE;
                    last_d  = 1'b0;
                    sel_d   = 1'b0;
                end
                pick2: begin
                    state_d = GNT2;
                    hold_d  = ONE;
                    last_d  = 1'b1;
                    sel_d   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hold_q  <= '0;
            turn_q  <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            arm1_q  <= 1'b1;
            arm2_q  <= 1'b1;
            to1_q   <= 1'b0;
            to2_q   <= 1'b0;
            g1_q    <= 1'b0;
            g2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            arm1_q  <= arm1_d;
            arm2_q  <= arm2_d;
            to1_q   <= to1_d;
            to2_q   <= to2_d;
            g1_q    <= (state_d == GNT1);
            g2_q    <= (state_d == GNT2);
        end
    end

    assign m1_bgrant  = g1_q;
    assign m2_bgrant  = g2_q;
    assign m1_timeout = to1_q;
    assign m2_timeout = to2_q;
    assign bus_sel    = sel_q;
    assign bus_busy   = g1_q | g2_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter.
// Two instances: A (TIMEOUT=8, TURNAROUND=1), B (TIMEOUT=0, TURNAROUND=3).
module tb_bus_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, a_r1, a_r2;
    logic a_g1, a_g2, a_t1, a_t2, a_sel, a_busy;
    logic rstn_b, b_r1, b_r2;
    logic b_g1, b_g2, b_t1, b_t2, b_sel, b_busy;

    bus_master_arbiter #(
        .TIMEOUT   (8),
        .TURNAROUND(1),
        .CNT_W     (16)
    ) dut_a (
        .clk       (clk),
        .rstn      (rstn_a),
        .m1_breq   (a_r1),
        .m2_breq   (a_r2),
        .m1_bgrant (a_g1),
        .m2_bgrant (a_g2),
        .m1_timeout(a_t1),
        .m2_timeout(a_t2),
        .bus_sel   (a_sel),
        .bus_busy  (a_busy)
    );

    bus_master_arbiter #(
        .TIMEOUT   (0),
        .TURNAROUND(3),
        .CNT_W     (16)
    ) dut_b (
        .clk       (clk),
        .rstn      (rstn_b),
        .m1_breq   (b_r1),
        .m2_breq   (b_r2),
        .m1_bgrant (b_g1),
        .m2_bgrant (b_g2),
        .m1_timeout(b_t1),
        .m2_timeout(b_t2),
        .bus_sel   (b_sel),
        .bus_busy  (b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: owner 0 = none, 1 = M1, 2 = M2.
    // gap = idle cycles still to run before arbitrating again.
    typedef struct {
        int owner;
        int held;
        int gap;
        int last;
        bit arm1;
        bit arm2;
        bit to1;
        bit to2;
        bit sel;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.owner = 0;
        m.held  = 0;
        m.gap   = 0;
        m.last  = 2;
        m.arm1  = 1'b1;
        m.arm2  = 1'b1;
        m.to1   = 1'b0;
        m.to2   = 1'b0;
        m.sel   = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit r1,
                                      input bit r2, input int tmo,
                                      input int ta);
        bit r[1:2];
        bit arm[1:2];
        bit e1, e2;
        int pick;
        r[1]   = r1;
        r[2]   = r2;
        arm[1] = m.arm1;
        arm[2] = m.arm2;
        m.to1  = 1'b0;
        m.to2  = 1'b0;
        if (m.owner != 0) begin
            if (!r[m.owner]) begin
                m.owner = 0;
                m.gap   = ta;
            end else if (tmo != 0 && m.held == tmo) begin
                if (m.owner == 1) m.to1 = 1'b1;
                else m.to2 = 1'b1;
                arm[m.owner] = 1'b0;
                m.owner = 0;
                m.gap   = ta;
            end else begin
                m.held++;
            end
        end else if (m.gap > 1) begin
            m.gap--;
        end else begin
            m.gap = 0;
            e1 = r[1] && arm[1];
            e2 = r[2] && arm[2];
            pick = 0;
            if (e1 && e2) pick = (m.last == 1) ? 2 : 1;
            else if (e1) pick = 1;
            else if (e2) pick = 2;
            if (pick != 0) begin
                m.owner = pick;
                m.held  = 1;
                m.last  = pick;
                m.sel   = (pick == 2);
            end
        end
        arm[1] = arm[1] | !r[1];
        arm[2] = arm[2] | !r[2];
        m.arm1 = arm[1];
        m.arm2 = arm[2];
        return m;
    endfunction

    function automatic logic [7:0] mdl_out(input mdl_t m);
        return {2'b00, m.owner == 1, m.owner == 2, m.to1, m.to2,
                m.sel, m.owner != 0};
    endfunction

    function automatic logic [7:0] outs_a();
        return {2'b00, a_g1, a_g2, a_t1, a_t2, a_sel, a_busy};
    endfunction

    function automatic logic [7:0] outs_b();
        return {2'b00, b_g1, b_g2, b_t1, b_t2, b_sel, b_busy};
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // One clock: step both models with the sampled inputs, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rstn_a) ma = mdl_init();
        else ma = mdl_step(ma, a_r1, a_r2, 8, 1);
        if (!rstn_b) mb = mdl_init();
        else mb = mdl_step(mb, b_r1, b_r2, 0, 3);
        #1;
        chk("model_a", outs_a(), mdl_out(ma));
        chk("model_b", outs_b(), mdl_out(mb));
        chk("excl_a", {7'd0, a_g1 & a_g2}, 8'd0);
        chk("excl_b", {7'd0, b_g1 & b_g2}, 8'd0);
    endtask

    typedef struct {
        bit r1, r2;
        bit g1, g2, t1, t2, sel;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int own;
        int exp_own;
        int bad;

        // r1 r2 | g1 g2 t1 t2 sel   (outputs after the edge)
        tbl = '{
            '{0,0, 0,0,0,0,0},
            '{1,1, 1,0,0,0,0},
            '{1,1, 1,0,0,0,0},
            '{0,1, 0,0,0,0,0},
            '{0,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,1,0,0,1},
            '{1,1, 0,0,0,1,1},
            '{1,1, 1,0,0,0,0},
            '{1,1, 1,0,0,0,0},
            '{0,1, 0,0,0,0,0},
            '{0,1, 0,0,0,0,0},
            '{0,0, 0,0,0,0,0},
            '{0,1, 0,1,0,0,1},
            '{0,0, 0,0,0,0,1},
            '{0,0, 0,0,0,0,1},
            '{1,0, 1,0,0,0,0}
        };

        rstn_a = 1'b0;
        rstn_b = 1'b0;
        a_r1 = 1'b0;
        a_r2 = 1'b0;
        b_r1 = 1'b0;
        b_r2 = 1'b0;
        ma = mdl_init();
        mb = mdl_init();
        #1;
        chk("reset_a", outs_a(), 8'd0);
        chk("reset_b", outs_b(), 8'd0);
        tick();
        tick();
        rstn_a = 1'b1;
        rstn_b = 1'b1;

        // Tie, release/turnaround, timeout, disarm and re-arm.
        for (int i = 0; i < 22; i++) begin
            a_r1 = tbl[i].r1;
            a_r2 = tbl[i].r2;
            tick();
            chk($sformatf("vec%0d", i), outs_a(),
                {2'b00, tbl[i].g1, tbl[i].g2, tbl[i].t1, tbl[i].t2,
                 tbl[i].sel, tbl[i].g1 | tbl[i].g2});
        end

        // Fairness: both keep re-requesting; last owner was M1.
        a_r1 = 1'b0;
        a_r2 = 1'b0;
        repeat (3) tick();
        a_r1 = 1'b1;
        a_r2 = 1'b1;
        exp_own = 2;
        for (int k = 0; k < 20; k++) begin
            own = 0;
            for (int w = 0; w < 20 && own == 0; w++) begin
                tick();
                if (a_g1) own = 1;
                else if (a_g2) own = 2;
            end
            chk($sformatf("fair%0d", k), 8'(own), 8'(exp_own));
            if (own == 1) a_r1 = 1'b0;
            else if (own == 2) a_r2 = 1'b0;
            tick();
            a_r1 = 1'b1;
            a_r2 = 1'b1;
            exp_own = 3 - exp_own;
        end

        // Reset during an M2 grant at hold count 5.
        a_r1 = 1'b0;
        a_r2 = 1'b0;
        repeat (3) tick();
        a_r2 = 1'b1;
        repeat (5) tick();
        chk("rst_pre", {6'd0, a_g1, a_g2}, 8'b01);
        a_r1 = 1'b1;
        rstn_a = 1'b0;
        #1;
        chk("rst_async", outs_a(), 8'd0);
        repeat (3) tick();
        rstn_a = 1'b1;
        tick();
        chk("rst_tie", {5'd0, a_g1, a_g2, a_sel}, 8'b100);

        // TIMEOUT=0: grant never revoked, even with M2 waiting.
        a_r1 = 1'b0;
        a_r2 = 1'b0;
        b_r1 = 1'b1;
        b_r2 = 1'b1;
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (!b_g1 || b_g2 || b_t1 || b_t2) bad++;
        end
        chk("no_timeout", 8'(bad), 8'd0);
        b_r1 = 1'b0;
        tick();
        chk("b_turn", outs_b(), 8'b0000_0000);
        tick();
        tick();
        tick();
        chk("b_gap3", outs_b(), 8'b0001_0011);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) a_r1 = ~a_r1;
            if ($urandom_range(0, 5) == 0) a_r2 = ~a_r2;
            if ($urandom_range(0, 9) == 0) b_r1 = ~b_r1;
            if ($urandom_range(0, 9) == 0) b_r2 = ~b_r2;
            if ($urandom_range(0, 599) == 0) begin
                rstn_a = 1'b0;
                #1;
                chk("rnd_rst", outs_a(), 8'd0);
                tick();
                rstn_a = 1'b1;
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
